md_issue_ctrl: RTL and testbench

//  EX-stage issue/interlock controller placed directly upstream of the multiply/divide unit.
//  - Decodes the E-stage MD op class and drives the unit's start/MDsel/mfsel/A/B inputs.
//  - Keeps a shadow busy countdown matching the unit's multiply and divide latency.
//  - Asserts stall_d so that no MD-class instruction leaves D while an MD operation is in flight.

---
 rtl/md_pkg.sv | 63 ++++++
 rtl/md_busy_cnt.sv | 78 +++++++
 rtl/md_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg
//
// Purpose:
//   Shared definitions for the multiply/divide datapath. The decoder, the
//   MD unit and the EX-stage issue controller use these so that all three
//   agree on what each MD op class means.
//
// Contents:
//   OP_*       4-bit MD op class carried down the pipeline
//   MDSEL_*    3-bit operation select presented to the MD unit
//   md_state_e IDLE/BUSY state of the shadow busy tracker
//   is_md()    op class touches the MD unit or HI/LO at all
//   is_start() op class launches a multi-cycle operation
//
// Op classes 9..15 are not defined and are treated exactly like OP_NONE.
// ----------------------------------------------------------------------------
package md_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [2:0] MDSEL_NONE  = 3'd0;
    localparam logic [2:0] MDSEL_MULT  = 3'd1;
    localparam logic [2:0] MDSEL_MULTU = 3'd2;
    localparam logic [2:0] MDSEL_DIV   = 3'd3;
    localparam logic [2:0] MDSEL_DIVU  = 3'd4;
    localparam logic [2:0] MDSEL_MTHI  = 3'd5;
    localparam logic [2:0] MDSEL_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Any op that touches the MD unit or HI/LO (mult/div/mt*/mf*).
    function automatic logic is_md(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MFLO);
    endfunction

    // Ops that launch a multi-cycle multiply or divide.
    function automatic logic is_start(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // Ops whose class maps directly onto an MDsel code (mult..mtlo).
    function automatic logic has_sel(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

    // Multiply-type starts use the shorter latency; divides use the longer one.
    function automatic logic is_mult(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// ----------------------------------------------------------------------------
// md_busy_cnt
//
// Purpose:
//   Loadable down-counter that shadows the MD unit's internal latency. A load
//   puts the tracker into BUSY with the operation's cycle count; it then
//   counts down once per cycle and drops back to IDLE after the last busy
//   cycle. busy is high for exactly load_val cycles after the load edge.
//
// Ports:
//   clk       in   1      clock
//   reset     in   1      synchronous, active-high
//   load      in   1      start of a new operation (wins over counting down)
//   load_val  in   CNT_W  busy length of the new operation, must be >= 1
//   busy      out  1      registered, high while state is BUSY
// ----------------------------------------------------------------------------
module md_busy_cnt
    import md_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // State and counter registers; reset returns to IDLE with an empty count
    // even if an operation was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load always (re)starts the countdown, even mid-operation, so the
    // shadow stays aligned with the MD unit which also restarts on a start
    // pulse. Otherwise BUSY counts down and leaves on the cnt == 1 cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = ST_BUSY;
            cnt_d   = load_val;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                end
                ST_BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q == ST_BUSY);

endmodule

// File: rtl/md_issue_ctrl.sv
// ----------------------------------------------------------------------------
// md_issue_ctrl
//
// Purpose:
//   EX-stage issue/interlock controller sitting directly in front of the
//   multiply/divide unit. It decodes the E-stage MD op class into the unit's
//   start/MDsel/mfsel/operand inputs, keeps a shadow busy countdown matching
//   the unit's latency, and stalls D so no MD-class instruction leaves D
//   while an MD operation is in flight.
//
// Optional feature:
//   MD_PERF_CNT_EN  when defined, perf_stall_cnt counts stall_d cycles
//                   (saturating); when undefined it is tied to zero.
//
// Ports:
//   clk             in   1   clock
//   reset           in   1   synchronous, active-high
//   d_valid         in   1   D stage holds a real instruction
//   d_op            in   4   D-stage MD op class
//   e_valid         in   1   E stage holds a real instruction
//   e_op            in   4   E-stage MD op class
//   e_rs_val        in   32  forwarded rs value in E
//   e_rt_val        in   32  forwarded rt value in E
//   md_start        out  1   start pulse to the MD unit (comb)
//   md_sel          out  3   MDsel to the MD unit (comb)
//   md_mfsel        out  1   0 = read HI, 1 = read LO (comb)
//   md_a            out  32  operand A = e_rs_val (comb)
//   md_b            out  32  operand B = e_rt_val (comb)
//   busy            out  1   shadow busy (registered)
//   stall_d         out  1   freeze PC/IF/D and bubble E (comb)
//   protocol_err    out  1   sticky: MD op reached E while busy
//   perf_stall_cnt  out 32   MD stall-cycle count
// ----------------------------------------------------------------------------
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [3:0]  d_op,
    input  logic        e_valid,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs_val,
    input  logic [31:0] e_rt_val,
    output logic        md_start,
    output logic [2:0]  md_sel,
    output logic        md_mfsel,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        busy,
    output logic        stall_d,
    output logic        protocol_err,
    output logic [31:0] perf_stall_cnt
);

    logic             e_md;
    logic [CNT_W-1:0] load_val;
    logic             protocol_err_q;

    // Issue decode. Only a valid E-stage instruction may select or start the
    // unit; undefined op classes fall through to MDSEL_NONE. mfsel only
    // steers the HI/LO read mux, so it follows e_op directly.
    always_comb begin
        md_start = 1'b0;
        md_sel   = MDSEL_NONE;
        e_md     = 1'b0;
        if (e_valid) begin
            md_start = is_start(e_op);
            e_md     = is_md(e_op);
            if (has_sel(e_op)) begin
                md_sel = e_op[2:0];
            end
        end
    end

    assign md_mfsel = (e_op == OP_MFLO);
    assign md_a     = e_rs_val;
    assign md_b     = e_rt_val;

    assign load_val = is_mult(e_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

    md_busy_cnt #(
        .CNT_W    (CNT_W)
    ) u_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (md_start),
        .load_val (load_val),
        .busy     (busy)
    );

    // md_start is included so the D-stage op is held back in the same cycle
    // that a new operation launches, before busy has had a chance to rise.
    // Moves to/from HI/LO wait too, since HI/LO are undefined mid-operation.
    assign stall_d = d_valid & is_md(d_op) & (busy | md_start);

    // Any MD op reaching E while busy means the interlock was bypassed
    // upstream; latch it until reset for debug visibility.
    always_ff @(posedge clk) begin
        if (reset) begin
            protocol_err_q <= 1'b0;
        end else if (e_md && busy) begin
            protocol_err_q <= 1'b1;
        end
    end

    assign protocol_err = protocol_err_q;

`ifdef MD_PERF_CNT_EN
    logic [31:0] perf_q;

    // Stall-cycle counter; holds at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (stall_d && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_md_issue_ctrl
//
// Scoreboard bench for md_issue_ctrl. The driver applies one input vector
// per cycle, predicts every output from a small behavioural model (remaining
// busy cycles as an integer, sticky error bit, stall count) and queues the
// prediction. A separate monitor pops one prediction per cycle at the
// falling edge and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_md_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [3:0]  d_op;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [31:0] e_rs_val;
    logic [31:0] e_rt_val;
    logic        md_start;
    logic [2:0]  md_sel;
    logic        md_mfsel;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        busy;
    logic        stall_d;
    logic        protocol_err;
    logic [31:0] perf_stall_cnt;

    always #5 clk = ~clk;

    md_issue_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .d_valid        (d_valid),
        .d_op           (d_op),
        .e_valid        (e_valid),
        .e_op           (e_op),
        .e_rs_val       (e_rs_val),
        .e_rt_val       (e_rt_val),
        .md_start       (md_start),
        .md_sel         (md_sel),
        .md_mfsel       (md_mfsel),
        .md_a           (md_a),
        .md_b           (md_b),
        .busy           (busy),
        .stall_d        (stall_d),
        .protocol_err   (protocol_err),
        .perf_stall_cnt (perf_stall_cnt)
    );

    typedef struct {
        logic        start;
        logic [2:0]  sel;
        logic        mfsel;
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
        logic        stall;
        logic        perr;
        logic [31:0] perf;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural reference state.
    int      busy_left = 0;
    bit      perr_m    = 1'b0;
    longint  perf_m    = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    // One cycle of stimulus plus its predicted response.
    task automatic applyStimulus(input logic rst, input logic dv, input logic [3:0] dop,
                                 input logic ev, input logic [3:0] eop);
        exp_t e;
        int   op_d;
        int   op_e;
        bit   m_busy;
        bit   m_start;
        bit   m_stall;
        @(posedge clk);
        #1;
        reset    = rst;
        d_valid  = dv;
        d_op     = dop;
        e_valid  = ev;
        e_op     = eop;
        e_rs_val = $urandom;
        e_rt_val = $urandom;

        op_d    = int'(dop);
        op_e    = int'(eop);
        m_busy  = (busy_left > 0);
        m_start = ev && (op_e >= 1) && (op_e <= 4);
        m_stall = dv && (op_d >= 1) && (op_d <= 8) && (m_busy || m_start);

        e.start = m_start;
        e.sel   = (ev && (op_e >= 1) && (op_e <= 6)) ? eop[2:0] : 3'd0;
        e.mfsel = (op_e == 8);
        e.a     = e_rs_val;
        e.b     = e_rt_val;
        e.busy  = m_busy;
        e.stall = m_stall;
        e.perr  = perr_m;
`ifdef MD_PERF_CNT_EN
        e.perf  = perf_m[31:0];
`else
        e.perf  = 32'd0;
`endif
        exp_q.push_back(e);

        if (rst) begin
            busy_left = 0;
            perr_m    = 1'b0;
            perf_m    = 0;
        end else begin
            if (ev && (op_e >= 1) && (op_e <= 8) && m_busy) perr_m = 1'b1;
            if (m_stall && perf_m < 64'h0000_0000_FFFF_FFFF) perf_m = perf_m + 1;
            if (m_start) busy_left = (op_e <= 2) ? MULT_LAT : DIV_LAT;
            else if (busy_left > 0) busy_left = busy_left - 1;
        end
    endtask

    // Monitor: one prediction per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                checkOutput("md_start", 32'(md_start), 32'(e.start));
                checkOutput("md_sel", 32'(md_sel), 32'(e.sel));
                checkOutput("md_mfsel", 32'(md_mfsel), 32'(e.mfsel));
                checkOutput("md_a", md_a, e.a);
                checkOutput("md_b", md_b, e.b);
                checkOutput("busy", 32'(busy), 32'(e.busy));
                checkOutput("stall_d", 32'(stall_d), 32'(e.stall));
                checkOutput("protocol_err", 32'(protocol_err), 32'(e.perr));
                checkOutput("perf_stall_cnt", perf_stall_cnt, e.perf);
            end
        end
    end

    initial begin
        logic [3:0] rop_d;
        logic [3:0] rop_e;
        reset    = 1'b1;
        d_valid  = 1'b0;
        d_op     = 4'd0;
        e_valid  = 1'b0;
        e_op     = 4'd0;
        e_rs_val = 32'd0;
        e_rt_val = 32'd0;
        repeat (2) @(posedge clk);

        // Reset state, then a lone MULT and its busy window.
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

        // DIVU in E with MFLO held in D until it may issue.
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b1, 4'd4);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd8);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

        // Non-MD op in D during busy passes; MTHI waits, then issues.
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd2);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd11, 1'b1, 4'd12);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd5);

        // Reset in the middle of a DIV.
        applyStimulus(1'b0, 1'b1, 4'd7, 1'b1, 4'd3);
        applyStimulus(1'b0, 1'b1, 4'd7, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd7, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd7, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

        // MULT forced into E while busy: sticky error and reload.
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, 4'd0);

        // Randomized traffic, MD ops in E kept fairly sparse.
        for (int i = 0; i < 3000; i++) begin
            rop_d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) rop_e = 4'($urandom_range(1, 8));
            else if ($urandom_range(0, 1) == 1) rop_e = 4'd0;
            else rop_e = 4'($urandom_range(9, 15));
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rop_d,
                          ($urandom_range(0, 3) != 0), rop_e);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
